// File: rtl/ace_pkg.sv
// Shared types and encodings for the ACE interconnect responder.
package ace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNP_AC  = 3'd1,
        ST_SNP_CR  = 3'd2,
        ST_SNP_CD  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_RESP = 3'd6
    } state_t;

    // ARSNOOP / ACSNOOP encodings
    localparam logic [3:0] SNOOP_READ_NO_SNOOP  = 4'b0000;
    localparam logic [3:0] SNOOP_READ_SHARED    = 4'b0001;
    localparam logic [3:0] AR_SNOOP_MAKE_UNIQUE = 4'b1100;
    localparam logic [3:0] AC_SNOOP_MAKE_UNIQUE = 4'b0111;

    // AR_DOMAIN values that require a snoop of the peer
    localparam logic [1:0] DOMAIN_INNER = 2'b01;
    localparam logic [1:0] DOMAIN_OUTER = 2'b10;

    // CR_RESP bit positions
    localparam int unsigned CR_DATA_TRANSFER = 0;
    localparam int unsigned CR_PASS_DIRTY    = 2;
    localparam int unsigned CR_IS_SHARED     = 3;

    // Response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ace_mem_array.sv
// Word-addressed backing store: synchronous write, combinational read, reset fill.
module ace_mem_array #(
    parameter int unsigned           WIDTH_D   = 32,
    parameter int unsigned           MEM_DEPTH = 16,
    parameter logic [WIDTH_D-1:0]    MEM_INIT  = '0,
    localparam int unsigned          IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [WIDTH_D-1:0] wdata_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic [WIDTH_D-1:0] rdata_o
);

    logic [WIDTH_D-1:0] mem_q [MEM_DEPTH];

    // Reset refills every word; otherwise a single-word write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= MEM_INIT;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ace_interconnect_responder.sv
// Single-master ACE interconnect + memory stub with one snooped peer cache.
module ace_interconnect_responder
    import ace_pkg::*;
#(
    parameter int unsigned        WIDTH_A   = 32,
    parameter int unsigned        WIDTH_D   = 32,
    parameter int unsigned        MEM_DEPTH = 16,
    parameter logic [WIDTH_D-1:0] MEM_INIT  = 32'hDEEDFEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ar_valid_i,
    output logic               ar_ready_o,
    input  logic [WIDTH_A-1:0] ar_addr_i,
    input  logic [3:0]         ar_snoop_i,
    input  logic [1:0]         ar_domain_i,
    output logic               r_valid_o,
    input  logic               r_ready_i,
    output logic [WIDTH_D-1:0] r_data_o,
    output logic [3:0]         r_resp_o,
    output logic               r_last_o,
    input  logic               aw_valid_i,
    output logic               aw_ready_o,
    input  logic [WIDTH_A-1:0] aw_addr_i,
    input  logic               w_valid_i,
    output logic               w_ready_o,
    input  logic [WIDTH_D-1:0] w_data_i,
    input  logic               w_last_i,
    output logic               b_valid_o,
    input  logic               b_ready_i,
    output logic [1:0]         b_resp_o,
    output logic               ac_valid_o,
    input  logic               ac_ready_i,
    output logic [WIDTH_A-1:0] ac_addr_o,
    output logic [3:0]         ac_snoop_o,
    input  logic               cr_valid_i,
    output logic               cr_ready_o,
    input  logic [4:0]         cr_resp_i,
    input  logic               cd_valid_i,
    output logic               cd_ready_o,
    input  logic [WIDTH_D-1:0] cd_data_i,
    input  logic               cd_last_i
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    state_t state_q, state_d;

    logic               idle_q, idle_d;
    logic               ac_valid_q, ac_valid_d;
    logic               cr_ready_q, cr_ready_d;
    logic               cd_ready_q, cd_ready_d;
    logic               r_valid_q, r_valid_d;
    logic               w_ready_q, w_ready_d;
    logic               b_valid_q, b_valid_d;

    logic [WIDTH_D-1:0] rdata_q, rdata_d;
    logic [3:0]         rresp_q, rresp_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [WIDTH_A-1:0] ac_addr_q, ac_addr_d;
    logic [3:0]         ac_snoop_q, ac_snoop_d;
    logic [IDX_W-1:0]   ar_idx_q, ar_idx_d;
    logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic               aw_oor_q, aw_oor_d;
    logic               cr_shared_q, cr_shared_d;
    logic               cr_dirty_q, cr_dirty_d;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_raddr;
    logic [WIDTH_D-1:0] mem_rdata;

    logic               ar_hs, aw_hs;
    logic               ar_oor, aw_oor;
    logic               unused_inputs;

    assign ar_hs  = ar_valid_i && idle_q;
    assign aw_hs  = aw_valid_i && idle_q && !ar_valid_i;
    assign ar_oor = |ar_addr_i[WIDTH_A-1:IDX_W+2];
    assign aw_oor = |aw_addr_i[WIDTH_A-1:IDX_W+2];

    // Reads come straight from the AR bus in IDLE, from the latched index afterwards.
    assign mem_raddr = (state_q == ST_IDLE) ? ar_addr_i[IDX_W+1:2] : ar_idx_q;

    assign unused_inputs = ^{ar_addr_i[1:0], aw_addr_i[1:0], cr_resp_i[4], cr_resp_i[1],
                             cd_last_i, w_last_i};

    ace_mem_array #(
        .WIDTH_D  (WIDTH_D),
        .MEM_DEPTH(MEM_DEPTH),
        .MEM_INIT (MEM_INIT)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we_i   (mem_we),
        .waddr_i(aw_idx_q),
        .wdata_i(w_data_i),
        .raddr_i(mem_raddr),
        .rdata_o(mem_rdata)
    );

    // Next-state, latched transaction fields and next handshake outputs.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        bresp_d     = bresp_q;
        ac_addr_d   = ac_addr_q;
        ac_snoop_d  = ac_snoop_q;
        ar_idx_d    = ar_idx_q;
        aw_idx_d    = aw_idx_q;
        aw_oor_d    = aw_oor_q;
        cr_shared_d = cr_shared_q;
        cr_dirty_d  = cr_dirty_q;
        mem_we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    ar_idx_d = ar_addr_i[IDX_W+1:2];
                    if (ar_oor) begin
                        rdata_d = '0;
                        rresp_d = {2'b00, RESP_DECERR};
                        state_d = ST_RD_RESP;
                    end else if (ar_domain_i == DOMAIN_INNER || ar_domain_i == DOMAIN_OUTER) begin
                        ac_addr_d  = ar_addr_i;
                        ac_snoop_d = (ar_snoop_i == AR_SNOOP_MAKE_UNIQUE) ? AC_SNOOP_MAKE_UNIQUE
                                                                          : SNOOP_READ_SHARED;
                        state_d    = ST_SNP_AC;
                    end else begin
                        rdata_d = mem_rdata;
                        rresp_d = 4'b0000;
                        state_d = ST_RD_RESP;
                    end
                end else if (aw_hs) begin
                    aw_idx_d = aw_addr_i[IDX_W+1:2];
                    aw_oor_d = aw_oor;
                    state_d  = ST_WR_DATA;
                end
            end
            ST_SNP_AC: begin
                if (ac_ready_i) state_d = ST_SNP_CR;
            end
            ST_SNP_CR: begin
                if (cr_valid_i) begin
                    cr_shared_d = cr_resp_i[CR_IS_SHARED];
                    cr_dirty_d  = cr_resp_i[CR_PASS_DIRTY];
                    if (cr_resp_i[CR_DATA_TRANSFER]) begin
                        state_d = ST_SNP_CD;
                    end else begin
                        rdata_d = mem_rdata;
                        rresp_d = {cr_resp_i[CR_IS_SHARED], 3'b000};
                        state_d = ST_RD_RESP;
                    end
                end
            end
            ST_SNP_CD: begin
                if (cd_valid_i) begin
                    rdata_d = cd_data_i;
                    rresp_d = {cr_shared_q, cr_dirty_q, 2'b00};
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (r_ready_i) state_d = ST_IDLE;
            end
            ST_WR_DATA: begin
                if (w_valid_i) begin
                    mem_we  = !aw_oor_q;
                    bresp_d = aw_oor_q ? RESP_DECERR : RESP_OKAY;
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        idle_d     = (state_d == ST_IDLE);
        ac_valid_d = (state_d == ST_SNP_AC);
        cr_ready_d = (state_d == ST_SNP_CR);
        cd_ready_d = (state_d == ST_SNP_CD);
        r_valid_d  = (state_d == ST_RD_RESP);
        w_ready_d  = (state_d == ST_WR_DATA);
        b_valid_d  = (state_d == ST_WR_RESP);
    end

    // State, handshake flags and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idle_q      <= 1'b0;
            ac_valid_q  <= 1'b0;
            cr_ready_q  <= 1'b0;
            cd_ready_q  <= 1'b0;
            r_valid_q   <= 1'b0;
            w_ready_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            bresp_q     <= '0;
            ac_addr_q   <= '0;
            ac_snoop_q  <= '0;
            ar_idx_q    <= '0;
            aw_idx_q    <= '0;
            aw_oor_q    <= 1'b0;
            cr_shared_q <= 1'b0;
            cr_dirty_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            ac_valid_q  <= ac_valid_d;
            cr_ready_q  <= cr_ready_d;
            cd_ready_q  <= cd_ready_d;
            r_valid_q   <= r_valid_d;
            w_ready_q   <= w_ready_d;
            b_valid_q   <= b_valid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            bresp_q     <= bresp_d;
            ac_addr_q   <= ac_addr_d;
            ac_snoop_q  <= ac_snoop_d;
            ar_idx_q    <= ar_idx_d;
            aw_idx_q    <= aw_idx_d;
            aw_oor_q    <= aw_oor_d;
            cr_shared_q <= cr_shared_d;
            cr_dirty_q  <= cr_dirty_d;
        end
    end

    assign ar_ready_o = idle_q;
    assign aw_ready_o = idle_q && !ar_valid_i;
    assign ac_valid_o = ac_valid_q;
    assign cr_ready_o = cr_ready_q;
    assign cd_ready_o = cd_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_last_o   = r_valid_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;
    assign r_data_o   = rdata_q;
    assign r_resp_o   = rresp_q;
    assign b_resp_o   = bresp_q;
    assign ac_addr_o  = ac_addr_q;
    assign ac_snoop_o = ac_snoop_q;

endmodule

// File: tb/tb_ace_interconnect_responder.sv
// Randomised bench for ace_interconnect_responder against a word-array memory model.
module tb_ace_interconnect_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0, ar_ready;
    logic [31:0] ar_addr = '0;
    logic [3:0]  ar_snoop = '0;
    logic [1:0]  ar_domain = '0;
    logic        r_valid, r_ready = 1'b0, r_last;
    logic [31:0] r_data;
    logic [3:0]  r_resp;
    logic        aw_valid = 1'b0, aw_ready;
    logic [31:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b1;
    logic [31:0] w_data = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ac_valid, ac_ready = 1'b0;
    logic [31:0] ac_addr;
    logic [3:0]  ac_snoop;
    logic        cr_valid = 1'b0, cr_ready;
    logic [4:0]  cr_resp = '0;
    logic        cd_valid = 1'b0, cd_ready, cd_last = 1'b1;
    logic [31:0] cd_data = '0;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] model_mem [16];

    always #5 clk = ~clk;

    ace_interconnect_responder dut (
        .clk(clk), .rst(rst),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
        .ar_snoop_i(ar_snoop), .ar_domain_i(ar_domain),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_resp_o(b_resp),
        .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr),
        .ac_snoop_o(ac_snoop),
        .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
        .cd_valid_i(cd_valid), .cd_ready_o(cd_ready), .cd_data_i(cd_data), .cd_last_i(cd_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 32'hDEEDFEED;
    endtask

    // One read transaction; peer answers with cr/cd, master stalls R for r_stall cycles.
    task automatic do_read(input logic [31:0] addr, input logic [1:0] dom, input logic [3:0] snp,
                           input logic [4:0] cr, input logic [31:0] cd, input int r_stall);
        int          n;
        bit          oor, snooped;
        logic [31:0] exp_data;
        logic [3:0]  exp_resp;
        logic [3:0]  exp_acs;
        oor     = (addr >> 2) >= 32'd16;
        snooped = !oor && (dom == 2'b01 || dom == 2'b10);
        exp_acs = (snp == 4'b1100) ? 4'b0111 : 4'b0001;
        if (oor) begin
            exp_data = 32'h0; exp_resp = 4'b0011;
        end else if (!snooped) begin
            exp_data = model_mem[addr[5:2]]; exp_resp = 4'b0000;
        end else if (cr[0]) begin
            exp_data = cd; exp_resp = {cr[3], cr[2], 2'b00};
        end else begin
            exp_data = model_mem[addr[5:2]]; exp_resp = {cr[3], 3'b000};
        end

        ar_valid = 1'b1; ar_addr = addr; ar_domain = dom; ar_snoop = snp;
        n = 0;
        while (!ar_ready && n < 20) begin step(); n++; end
        total++; if (n >= 20) $display("FAIL rd_ar_timeout addr=%h", addr); else pass_cnt++;
        step();
        ar_valid = 1'b0;

        if (snooped) begin
            total++; if (ac_valid !== 1'b1 || r_valid !== 1'b0)
                $display("FAIL rd_ac_valid got ac=%b r=%b req ac=1 r=0", ac_valid, r_valid); else pass_cnt++;
            total++; if (ac_snoop !== exp_acs || ac_addr !== addr)
                $display("FAIL rd_ac_fields got snoop=%b addr=%h req snoop=%b addr=%h", ac_snoop, ac_addr, exp_acs, addr); else pass_cnt++;
            repeat ($urandom_range(0, 2)) step();
            total++; if (ac_valid !== 1'b1) $display("FAIL rd_ac_hold got=%b req=1", ac_valid); else pass_cnt++;
            ac_ready = 1'b1; step(); ac_ready = 1'b0;
            total++; if (cr_ready !== 1'b1 || ac_valid !== 1'b0)
                $display("FAIL rd_cr_ready got cr=%b ac=%b req cr=1 ac=0", cr_ready, ac_valid); else pass_cnt++;
            repeat ($urandom_range(0, 2)) step();
            cr_valid = 1'b1; cr_resp = cr; step(); cr_valid = 1'b0;
            if (cr[0]) begin
                total++; if (cd_ready !== 1'b1 || r_valid !== 1'b0)
                    $display("FAIL rd_cd_ready got cd=%b r=%b req cd=1 r=0", cd_ready, r_valid); else pass_cnt++;
                repeat ($urandom_range(0, 2)) step();
                cd_valid = 1'b1; cd_data = cd; step(); cd_valid = 1'b0;
            end else begin
                total++; if (cd_ready !== 1'b0) $display("FAIL rd_no_cd got=%b req=0", cd_ready); else pass_cnt++;
            end
        end else begin
            total++; if (ac_valid !== 1'b0) $display("FAIL rd_no_snoop ac_valid got=%b req=0", ac_valid); else pass_cnt++;
        end

        total++; if (r_valid !== 1'b1 || r_last !== 1'b1)
            $display("FAIL rd_r_valid got valid=%b last=%b req 1/1 addr=%h", r_valid, r_last, addr); else pass_cnt++;
        total++; if (r_data !== exp_data || r_resp !== exp_resp)
            $display("FAIL rd_data addr=%h got data=%h resp=%b req data=%h resp=%b", addr, r_data, r_resp, exp_data, exp_resp); else pass_cnt++;
        for (int s = 0; s < r_stall; s++) begin
            step();
            total++; if (r_valid !== 1'b1 || r_data !== exp_data || r_resp !== exp_resp || aw_ready !== 1'b0)
                $display("FAIL rd_stall got valid=%b data=%h resp=%b awr=%b req 1/%h/%b/0", r_valid, r_data, r_resp, aw_ready, exp_data, exp_resp); else pass_cnt++;
        end
        r_ready = 1'b1; step(); r_ready = 1'b0;
        total++; if (r_valid !== 1'b0 || ar_ready !== 1'b1)
            $display("FAIL rd_done got r_valid=%b ar_ready=%b req 0/1", r_valid, ar_ready); else pass_cnt++;
    endtask

    // One write transaction with W delay and B stall.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int b_stall);
        int         n;
        bit         oor;
        logic [1:0] exp_b;
        oor   = (addr >> 2) >= 32'd16;
        exp_b = oor ? 2'b11 : 2'b00;
        aw_valid = 1'b1; aw_addr = addr;
        n = 0;
        while (!aw_ready && n < 20) begin step(); n++; end
        total++; if (n >= 20) $display("FAIL wr_aw_timeout addr=%h", addr); else pass_cnt++;
        step();
        aw_valid = 1'b0;
        total++; if (w_ready !== 1'b1 || b_valid !== 1'b0)
            $display("FAIL wr_w_ready got w=%b b=%b req 1/0", w_ready, b_valid); else pass_cnt++;
        repeat ($urandom_range(0, 2)) step();
        w_valid = 1'b1; w_data = data; w_last = 1'b1; step(); w_valid = 1'b0;
        if (!oor) model_mem[addr[5:2]] = data;
        total++; if (b_valid !== 1'b1 || b_resp !== exp_b || w_ready !== 1'b0)
            $display("FAIL wr_b addr=%h got valid=%b resp=%b w=%b req 1/%b/0", addr, b_valid, b_resp, w_ready, exp_b); else pass_cnt++;
        for (int s = 0; s < b_stall; s++) begin
            step();
            total++; if (b_valid !== 1'b1 || b_resp !== exp_b)
                $display("FAIL wr_stall got valid=%b resp=%b req 1/%b", b_valid, b_resp, exp_b); else pass_cnt++;
        end
        b_ready = 1'b1; step(); b_ready = 1'b0;
        total++; if (b_valid !== 1'b0 || ar_ready !== 1'b1)
            $display("FAIL wr_done got b_valid=%b ar_ready=%b req 0/1", b_valid, ar_ready); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) step();
        total++; if (ar_ready !== 1'b0 || aw_ready !== 1'b0)
            $display("FAIL reset_ready got ar=%b aw=%b req 0/0", ar_ready, aw_ready); else pass_cnt++;
        total++; if ({r_valid, b_valid, ac_valid, cr_ready, cd_ready, w_ready, r_last} !== 7'b0)
            $display("FAIL reset_hs got %b req 0", {r_valid, b_valid, ac_valid, cr_ready, cd_ready, w_ready, r_last}); else pass_cnt++;
        total++; if (r_data !== 32'h0 || r_resp !== 4'h0 || b_resp !== 2'b0 || ac_addr !== 32'h0 || ac_snoop !== 4'h0)
            $display("FAIL reset_data got rd=%h rr=%b b=%b aca=%h acs=%b req zeros", r_data, r_resp, b_resp, ac_addr, ac_snoop); else pass_cnt++;
        rst = 1'b0;
        step();
        total++; if (ar_ready !== 1'b1 || aw_ready !== 1'b1)
            $display("FAIL reset_release got ar=%b aw=%b req 1/1", ar_ready, aw_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        do_read(32'h0, 2'b00, 4'b0000, 5'b0, 32'h0, 0);
        do_write(32'h8, 32'hABCDABCD, 0);
        do_read(32'h8, 2'b00, 4'b0000, 5'b0, 32'h0, 0);
        do_read(32'hC, 2'b10, 4'b0001, 5'b01001, 32'hFACEFABE, 0);
        do_read(32'h8, 2'b10, 4'b1100, 5'b00000, 32'h0, 0);
        do_read(32'h8, 2'b10, 4'b1100, 5'b00101, 32'h12345678, 0);
        do_read(32'h40, 2'b01, 4'b0001, 5'b00001, 32'h0, 1);
    endtask

    task automatic test_ar_aw_collision();
        ar_valid = 1'b1; ar_addr = 32'h4; ar_domain = 2'b00;
        aw_valid = 1'b1; aw_addr = 32'h4;
        #1;
        total++; if (ar_ready !== 1'b1 || aw_ready !== 1'b0)
            $display("FAIL collide_ready got ar=%b aw=%b req 1/0", ar_ready, aw_ready); else pass_cnt++;
        do_read(32'h4, 2'b00, 4'b0000, 5'b0, 32'h0, 3);
        total++; if (aw_ready !== 1'b1) $display("FAIL collide_aw_next got=%b req=1", aw_ready); else pass_cnt++;
        do_write(32'h4, 32'h5A5A0001, 3);
        do_read(32'h4, 2'b00, 4'b0000, 5'b0, 32'h0, 0);
    endtask

    task automatic test_reset_mid_snoop();
        ar_valid = 1'b1; ar_addr = 32'h8; ar_domain = 2'b01; ar_snoop = 4'b0001;
        step(); ar_valid = 1'b0;
        ac_ready = 1'b1; step(); ac_ready = 1'b0;
        cr_valid = 1'b1; cr_resp = 5'b00001; step(); cr_valid = 1'b0;
        total++; if (cd_ready !== 1'b1) $display("FAIL midrst_in_cd got=%b req=1", cd_ready); else pass_cnt++;
        rst = 1'b1;
        step();
        model_reset();
        total++; if ({ac_valid, cr_ready, cd_ready, r_valid, ar_ready, aw_ready} !== 6'b0)
            $display("FAIL midrst_hs got %b req 0", {ac_valid, cr_ready, cd_ready, r_valid, ar_ready, aw_ready}); else pass_cnt++;
        rst = 1'b0;
        step();
        do_read(32'h8, 2'b00, 4'b0000, 5'b0, 32'h0, 0);
        do_write(32'h100, 32'hBADBAD00, 0);
        do_read(32'h0, 2'b00, 4'b0000, 5'b0, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int t = 0; t < 40; t++) begin
            addr = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h40 << $urandom_range(0, 8));
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, $urandom_range(0, 2));
            else
                do_read(addr, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 4'b1100 : 4'b0001,
                        5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ar_aw_collision();
        test_reset_mid_snoop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/ace_interconnect_responder.md
# ace_interconnect_responder

Synthesizable single-master ACE responder that sits on the cache's AR/AW/W/R/B master ports and acts as the interconnect plus backing memory. For reads it snoops one peer cache over AC/CR/CD and returns either the peer's data or memory data on R. For writes it updates memory and returns B. It replaces the behavioural interconnect/memory model used by the cache top-level bench with real RTL, and is also usable as the system-level memory stub.

## Interface
- WIDTH_A, 32, address width
- WIDTH_D, 32, data width
- MEM_DEPTH, 16, memory words (power of two), word-indexed by ADDR[$clog2(MEM_DEPTH)+1:2]
- MEM_INIT, 32'hDEEDFEED, value every word takes on reset
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- AR_VALID / AR_READY  in / out  1 / 1  read-address handshake
- AR_ADDR / AR_SNOOP / AR_DOMAIN  in  WIDTH_A / 4 / 2  read address and transaction type
- R_VALID / R_READY  out / in  1 / 1  read-data handshake
- RDATA / RRESP / R_LAST  out  WIDTH_D / 4 / 1  read data; RRESP[3]=IsShared, [2]=PassDirty, [1:0]=resp
- AW_VALID / AW_READY  in / out  1 / 1  write-address handshake
- AW_ADDR  in  WIDTH_A  write address
- W_VALID / W_READY  in / out  1 / 1  write-data handshake
- W_DATA / W_LAST  in  WIDTH_D / 1  write data (single beat, W_LAST expected 1)
- B_VALID / B_READY / BRESP  out / in / out  1 / 1 / 2  write response
- AC_VALID / AC_READY  out / in  1 / 1  snoop-address handshake to peer cache
- AC_ADDR / AC_SNOOP  out  WIDTH_A / 4  snoop address and type
- CR_VALID / CR_READY / CR_RESP  in / out / in  1 / 1 / 5  snoop response; [0]=DataTransfer, [2]=PassDirty, [3]=IsShared
- CD_VALID / CD_READY / CD_DATA / CD_LAST  in / out / in / in  1 / 1 / WIDTH_D / 1  snoop data (single beat)

## Operation
- Moore FSM, states: IDLE, SNP_AC, SNP_CR, SNP_CD, RD_RESP, WR_DATA, WR_RESP.
- IDLE: AR_READY=1; AW_READY = !AR_VALID (AR wins when both valid). Handshake = VALID&&READY at rising edge.
- AR accepted: latch address/type. Out-of-range (word index ≥ MEM_DEPTH) → RD_RESP with RDATA=0, RRESP=4'b0011. AR_DOMAIN ∈ {01,10} → SNP_AC; otherwise → RD_RESP with RDATA = mem[idx], RRESP=0.
- Snoop type: AR_SNOOP 4'b1100 → AC_SNOOP 4'b0111; all other snooped reads → AC_SNOOP 4'b0001. AC_ADDR = latched AR_ADDR.
- SNP_AC: AC_VALID=1 until AC_READY → SNP_CR. SNP_CR: CR_READY=1; on CR handshake latch CR_RESP; CR_RESP[0]=1 → SNP_CD, else → RD_RESP with mem data, RRESP = {CR_RESP[3],3'b000}.
- SNP_CD: CD_READY=1; on CD handshake RDATA = CD_DATA, RRESP = {CR_RESP[3],CR_RESP[2],2'b00} → RD_RESP. Memory is not updated from snoop data.
- RD_RESP: R_VALID=1, R_LAST=1, RDATA/RRESP stable until R_READY → IDLE.
- AW accepted: latch address → WR_DATA (W_READY=1). On W handshake write mem[idx]=W_DATA if in range → WR_RESP with BRESP=00 (in range) or 11 (out of range, write dropped). WR_RESP: B_VALID=1 until B_READY → IDLE.
- Reset (any state, mid-transaction included): state=IDLE, every mem word = MEM_INIT, all VALID outputs 0, CR_READY/CD_READY/W_READY 0, RDATA=0, RRESP=0, BRESP=0, AC_ADDR=0, AC_SNOOP=0, R_LAST=0. AR_READY/AW_READY follow IDLE rules in the cycle after reset deasserts; both are 0 while rst=1.
- Only one transaction outstanding; no IDs, single-beat bursts only.

## Timing
- All handshake outputs are decoded from the state register only; data outputs are registered.
- Non-snooped read: AR handshake at edge N → R_VALID high after edge N (visible in cycle N+1).
- Snooped read, no data: AR@N → AC_VALID cycle N+1. AC handshake @M → CR_READY from M+1. CR handshake @K → R_VALID from K+1.
- Snooped read with data: CD handshake @J → R_VALID from J+1.
- Write: AW@N → W_READY from N+1. W@M → memory updated and B_VALID from M+1.
- Back-to-back: the next AR/AW can be accepted in the first IDLE cycle after R/B handshake (one-cycle bubble).
- VALID outputs never deassert without a handshake; data is stable while VALID && !READY.

## Structure
- Shared package ace_pkg: state enum, AR_SNOOP/AC_SNOOP encodings (READ_SHARED, MAKE_UNIQUE, READ_NO_SNOOP), CR_RESP bit indices, RESP_OKAY/RESP_DECERR constants.
- One sub-module, ace_mem_array: MEM_DEPTH×WIDTH_D, synchronous write, combinational read, synchronous reset fill to MEM_INIT.

## Test plan
- Reset, then AR ADDR=0x0, DOMAIN=00 → R_VALID at AR+1, RDATA=0xDEEDFEED, RRESP=0, R_LAST=1; no AC_VALID.
- AW ADDR=0x8, W_DATA=0xABCDABCD → BRESP=00; then a non-snoop read of 0x8 → RDATA=0xABCDABCD.
- AR ADDR=0xC, DOMAIN=10, SNOOP=0001; peer CR_RESP=5'b01001, CD_DATA=0xFACEFABE → AC_SNOOP=0001, RDATA=0xFACEFABE, RRESP=4'b1000.
- AR SNOOP=1100, DOMAIN=10; CR_RESP=0 → AC_SNOOP=0111, no CD_READY, RDATA=mem value, RRESP=0; repeat with CR_RESP=5'b00101 → RRESP=4'b0100.
- AR_VALID and AW_VALID asserted in the same cycle → AR accepted, AW_READY=0 until the read completes; the write is served next. Assert R_READY/B_READY low for 3 cycles → data held stable.
- rst pulsed during SNP_CD → IDLE next cycle, AC/CR/CD/R ready/valid all 0, mem[2]=0xDEEDFEED; AW to 0x100 → BRESP=11, memory unchanged.
